// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Request/result bundle between the core and the multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface muldiv_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic             signed_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             stall;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, op, signed_op, operand_a, operand_b,
    input  result, busy, done, stall, negative, zero, overflow, div_zero
  );

  modport slave (
    input  start, op, signed_op, operand_a, operand_b,
    output result, busy, done, stall, negative, zero, overflow, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative radix-2 MUL/MULH/DIV/REM unit, WIDTH+2 cycle fixed latency.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  muldiv_if.slave   bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               signed_q, signed_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               bz_q, bz_d;
  logic               ovc_q, ovc_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   divr_q, divr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic               sgn_in, sa_in, sb_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_mul, step_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_fix;
  logic               ovf_fix, dz_fix;

  // Operands are held as magnitudes; signs are reapplied in FIX.
  assign sgn_in = SIGNED_EN & bus.signed_op;
  assign sa_in  = sgn_in & bus.operand_a[WIDTH-1];
  assign sb_in  = sgn_in & bus.operand_b[WIDTH-1];
  assign mag_a  = sa_in ? -bus.operand_a : bus.operand_a;
  assign mag_b  = sb_in ? -bus.operand_b : bus.operand_b;

  // Shift-add: multiplier in acc low half, partial product builds in high half.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, divr_q} : '0);
  assign step_mul = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: remainder in high half, dividend shifts out as quotient shifts in.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, divr_q};
  assign div_qbit  = ~div_diff[WIDTH+1];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign step_div  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_fix  = '0;
    ovf_fix  = 1'b0;
    dz_fix   = 1'b0;
    case (op_q)
      2'b00: begin
        res_fix = prod_fix[WIDTH-1:0];
        ovf_fix = signed_q ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                           : (prod_fix[2*WIDTH-1:WIDTH] != '0);
      end
      2'b01: res_fix = prod_fix[2*WIDTH-1:WIDTH];
      2'b10: begin
        res_fix = bz_q ? ALL_ONES : quo_fix;
        ovf_fix = ovc_q;
        dz_fix  = bz_q;
      end
      default: begin
        res_fix = bz_q ? a_raw_q : rem_fix;
        ovf_fix = ovc_q;
        dz_fix  = bz_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bz_d     = bz_q;
    ovc_d    = ovc_q;
    a_raw_d  = a_raw_q;
    divr_d   = divr_q;
    acc_d    = acc_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = CNT_INIT;
          op_d     = bus.op;
          signed_d = sgn_in;
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          bz_d     = (bus.operand_b == '0);
          ovc_d    = sgn_in && (bus.operand_a == MIN_VAL) && (bus.operand_b == ALL_ONES);
          a_raw_d  = bus.operand_a;
          divr_d   = bus.op[1] ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? step_div : step_mul;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = res_fix;
        neg_d    = res_fix[WIDTH-1];
        zero_d   = (res_fix == '0);
        ovf_d    = ovf_fix;
        dz_d     = dz_fix;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bz_q     <= 1'b0;
      ovc_q    <= 1'b0;
      a_raw_q  <= '0;
      divr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bz_q     <= bz_d;
      ovc_q    <= ovc_d;
      a_raw_q  <= a_raw_d;
      divr_q   <= divr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.negative = neg_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.stall    = bus.busy || (bus.start && (state_q == S_IDLE));
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit (16-bit signed, 8-bit unsigned).
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   lat, bcnt, dcnt;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(16)) m16 ();
  muldiv_if #(.WIDTH(8))  m8  ();

  muldiv_unit #(.WIDTH(16), .SIGNED_EN(1'b1)) u16 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (m16.slave)
  );

  muldiv_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) u8 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (m8.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue16(input logic [1:0] op, input logic sop,
                         input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    m16.op = op; m16.signed_op = sop; m16.operand_a = a; m16.operand_b = b;
    m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
  endtask

  // Entered #1 after the start edge; lat counts edges since the start cycle.
  task automatic wait16(output int l, output int bc);
    l  = 1;
    bc = m16.busy ? 1 : 0;
    while (!m16.done && l < 60) begin
      @(posedge clk); #1;
      l++;
      if (m16.busy) bc++;
    end
    check("done16_seen", {31'd0, m16.done}, 32'd1);
  endtask

  task automatic run16(input logic [1:0] op, input logic sop,
                       input logic [15:0] a, input logic [15:0] b);
    issue16(op, sop, a, b);
    wait16(lat, bcnt);
  endtask

  task automatic run8(input logic [1:0] op, input logic sop,
                      input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    m8.op = op; m8.signed_op = sop; m8.operand_a = a; m8.operand_b = b;
    m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    lat = 1;
    while (!m8.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done8_seen", {31'd0, m8.done}, 32'd1);
  endtask

  initial begin
    m16.start = 1'b0; m16.op = '0; m16.signed_op = 1'b0; m16.operand_a = '0; m16.operand_b = '0;
    m8.start  = 1'b0; m8.op  = '0; m8.signed_op  = 1'b0; m8.operand_a  = '0; m8.operand_b  = '0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", {16'd0, m16.result}, 32'h0);
    check("rst_busy",   {31'd0, m16.busy},   32'h0);
    check("rst_done",   {31'd0, m16.done},   32'h0);
    check("rst_flags",  {28'd0, m16.negative, m16.zero, m16.overflow, m16.div_zero}, 32'h0);
    check("rst_stall",  {31'd0, m16.stall},  32'h0);
    rst_n = 1'b1;

    // Stall rises combinationally on a request in IDLE; withdraw it before the edge.
    @(negedge clk);
    m16.start = 1'b1; #1;
    check("stall_req_idle", {31'd0, m16.stall}, 32'h1);
    m16.start = 1'b0; #1;
    check("stall_no_req", {31'd0, m16.stall}, 32'h0);

    run16(OP_MUL, 1'b0, 16'h0007, 16'h0006);
    check("mul_u_result", {16'd0, m16.result}, 32'h002A);
    check("mul_u_ovf",    {31'd0, m16.overflow}, 32'h0);
    check("mul_u_latency", lat, 32'd18);
    check("mul_u_busy_cycles", bcnt, 32'd17);
    check("stall_in_done", {31'd0, m16.stall}, 32'h0);

    run16(OP_MUL, 1'b1, 16'h8000, 16'h8000);
    check("mul_s_min_result", {16'd0, m16.result}, 32'h0000);
    check("mul_s_min_ovf",    {31'd0, m16.overflow}, 32'h1);
    check("mul_s_min_zero",   {31'd0, m16.zero}, 32'h1);

    run16(OP_MULH, 1'b1, 16'h8000, 16'h8000);
    check("mulh_s_min_result", {16'd0, m16.result}, 32'h4000);
    check("mulh_s_min_neg",    {31'd0, m16.negative}, 32'h0);
    check("mulh_s_min_ovf",    {31'd0, m16.overflow}, 32'h0);

    run16(OP_MUL, 1'b1, 16'hFFFD, 16'h0003);
    check("mul_s_neg_result", {16'd0, m16.result}, 32'hFFF7);
    check("mul_s_neg_ovf",    {31'd0, m16.overflow}, 32'h0);
    check("mul_s_neg_neg",    {31'd0, m16.negative}, 32'h1);

    run16(OP_DIV, 1'b0, 16'd100, 16'd7);
    check("div_u_result", {16'd0, m16.result}, 32'h000E);
    run16(OP_REM, 1'b0, 16'd100, 16'd7);
    check("rem_u_result", {16'd0, m16.result}, 32'h0002);

    run16(OP_DIV, 1'b1, 16'hFFF9, 16'h0002);
    check("div_s_result", {16'd0, m16.result}, 32'hFFFD);
    check("div_s_neg",    {31'd0, m16.negative}, 32'h1);
    run16(OP_REM, 1'b1, 16'hFFF9, 16'h0002);
    check("rem_s_result", {16'd0, m16.result}, 32'hFFFF);
    check("rem_s_neg",    {31'd0, m16.negative}, 32'h1);

    run16(OP_DIV, 1'b0, 16'h1234, 16'h0000);
    check("div0_result",  {16'd0, m16.result}, 32'hFFFF);
    check("div0_flag",    {31'd0, m16.div_zero}, 32'h1);
    check("div0_latency", lat, 32'd18);
    run16(OP_REM, 1'b0, 16'h1234, 16'h0000);
    check("rem0_result",  {16'd0, m16.result}, 32'h1234);
    check("rem0_flag",    {31'd0, m16.div_zero}, 32'h1);

    // A multiply clears div_zero; 0x100*0x100 spills entirely into the high half.
    run16(OP_MUL, 1'b0, 16'h0100, 16'h0100);
    check("mul_u_big_result", {16'd0, m16.result}, 32'h0000);
    check("mul_u_big_ovf",    {31'd0, m16.overflow}, 32'h1);
    check("mul_clears_dz",    {31'd0, m16.div_zero}, 32'h0);

    run16(OP_DIV, 1'b1, 16'h8000, 16'hFFFF);
    check("div_ovf_result", {16'd0, m16.result}, 32'h8000);
    check("div_ovf_flag",   {31'd0, m16.overflow}, 32'h1);
    run16(OP_REM, 1'b1, 16'h8000, 16'hFFFF);
    check("rem_ovf_result", {16'd0, m16.result}, 32'h0000);
    check("rem_ovf_flag",   {31'd0, m16.overflow}, 32'h1);

    // Second request mid-run must not disturb the latched operation.
    issue16(OP_DIV, 1'b0, 16'd100, 16'd7);
    repeat (4) begin @(posedge clk); #1; end
    m16.op = OP_MUL; m16.operand_a = 16'h0003; m16.operand_b = 16'h0003; m16.start = 1'b1;
    @(posedge clk); #1;
    m16.start = 1'b0;
    wait16(lat, bcnt);
    check("ignored_start_result", {16'd0, m16.result}, 32'h000E);
    check("ignored_start_latency", lat, 32'd13);

    // Abort mid-run with reset; result register held 0x000E beforehand.
    issue16(OP_MUL, 1'b0, 16'h0007, 16'h0006);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check("abort_result", {16'd0, m16.result}, 32'h0);
    check("abort_busy",   {31'd0, m16.busy}, 32'h0);
    check("abort_done",   {31'd0, m16.done}, 32'h0);
    check("abort_stall",  {31'd0, m16.stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m16.done) dcnt++;
    end
    check("abort_no_done", dcnt, 32'd0);
    run16(OP_MUL, 1'b0, 16'h0007, 16'h0006);
    check("after_abort_result",  {16'd0, m16.result}, 32'h002A);
    check("after_abort_latency", lat, 32'd18);

    // 8-bit unsigned-only instance ignores signed_op.
    run8(OP_MULH, 1'b1, 8'hFF, 8'hFF);
    check("w8_mulh_result",  {24'd0, m8.result}, 32'h00FE);
    check("w8_mulh_latency", lat, 32'd10);
    run8(OP_MUL, 1'b1, 8'hFF, 8'hFF);
    check("w8_mul_result", {24'd0, m8.result}, 32'h0001);
    check("w8_mul_ovf",    {31'd0, m8.overflow}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide execution unit for the 16-bit RISC datapath, extending the single-cycle ALU and shifter with MUL, MULH, DIV and REM. It sits beside the ALU and takes the same operand sources (register read data 1, and ALU input 2 from register or immediate). Writeback uses a spare select of the writeback mux; flags feed the CPSR flag muxes. While the unit runs, a stall output freezes the PC manager and register writes.

## Interface
- WIDTH, 16, operand/result width in bits (≥4)
- SIGNED_EN, 1, 1 = signed ops honoured; 0 = `signed_op` ignored, all ops unsigned
- CNT_W, derived $clog2(WIDTH+1), iteration counter width (localparam)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
- signed_op  in  1  two's-complement operands when SIGNED_EN=1
- operand_a  in  WIDTH  multiplicand / dividend
- operand_b  in  WIDTH  multiplier / divisor
- result  out  WIDTH  selected result; held until next accepted start
- busy  out  1  unit in RUN or FIX
- done  out  1  one-cycle pulse, result and flags valid
- stall  out  1  combinational: busy | (start & state==IDLE)
- negative  out  1  result[WIDTH-1]
- zero  out  1  result == 0
- overflow  out  1  see Operation
- div_zero  out  1  DIV/REM with operand_b == 0

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 latches op, signed_op, operands. When signed, it latches magnitudes plus sign bits. Counter loads WIDTH; go to RUN.
- RUN, MUL/MULH: radix-2 shift-add over a 2·WIDTH product register, one multiplier bit per cycle.
- RUN, DIV/REM: restoring division, one quotient bit per cycle.
- RUN lasts exactly WIDTH cycles, counter decrements to 0, then FIX.
- FIX: applies sign correction and selects the result half, then computes flags; go to DONE.
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder takes sign of dividend.
- DONE: done=1 for one cycle; next cycle IDLE. A start during DONE is ignored.
- Start while busy or in DONE: ignored, no effect on latched operands.
- Divide by zero: quotient = all ones, remainder = operand_a (unmodified), div_zero=1. Same latency as normal ops.
- Signed overflow, DIV/REM with a = 100…0 and b = all ones: quotient = 100…0, remainder = 0, overflow=1.
- MUL overflow=1 when the full product does not fit in WIDTH bits (unsigned: high half ≠ 0; signed: high half ≠ sign extension of low half). MULH overflow=0.
- Flags and result update only in FIX; they hold otherwise.
- div_zero is cleared on MUL/MULH.

## Timing
- Reset (reset=0, asynchronous): state=IDLE.
  - result, busy, done, negative, zero, overflow, div_zero all 0; counter 0.
  - stall follows its equation, so it reads 0 with start=0.
- Start sampled at edge E0. busy=1 for cycles E0+1 … E0+WIDTH+1 (RUN ×WIDTH, FIX ×1).
- done=1 in the cycle after edge E0+WIDTH+1. Total latency WIDTH+2 cycles, constant for all ops and operand values.
- stall high from the start cycle through the last FIX cycle; low in DONE, when the core captures result.
- Back-to-back throughput: a new start is accepted in the cycle after DONE. Minimum period WIDTH+3 cycles.
- Reset asserted mid-RUN/FIX aborts immediately. The operation is lost; no done.

## Test plan
- WIDTH=16, MUL unsigned 0x0007 × 0x0006 → result 0x002A, overflow=0. done exactly 18 cycles after start; busy high 17 cycles.
- MUL/MULH signed 0x8000 × 0x8000 → MUL result 0x0000, overflow=1; MULH result 0x4000, negative=0.
- DIV/REM unsigned 100 / 7 → 0x000E and 0x0002. Signed 0xFFF9 / 0x0002 → DIV 0xFFFD, REM 0xFFFF, negative=1.
- Divide by zero 0x1234 / 0 → DIV 0xFFFF, REM 0x1234, div_zero=1. Signed 0x8000 / 0xFFFF → DIV 0x8000, overflow=1, REM 0x0000.
- Start pulsed again at RUN cycle 5 with different operands → ignored, original result returned. Reset pulled low at RUN cycle 8 → all outputs 0 next sample, no done; fresh op then completes normally.
- SIGNED_EN=0, WIDTH=8: signed_op=1, 0xFF × 0xFF MULH → 0xFE (unsigned). done 10 cycles after start.
